// File: rtl/led_pwm_drive_pkg.sv
// Shared types for the multi-channel LED PWM driver.
// Mode encodings, channel index width and the config record.
package led_pkg;

  localparam int CH_W         = 4;
  localparam int DEF_PERIOD_W = 16;
  localparam int DEF_PWM_BITS = 8;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

  typedef struct packed {
    mode_t                   mode;
    logic [DEF_PERIOD_W-1:0] period;
    logic [DEF_PWM_BITS-1:0] duty;
  } cfg_t;

endpackage

// File: rtl/led_pwm_drive_if.sv
// Configuration write port of the LED driver.
// One channel is written per accepted valid/ready beat.
interface led_pwm_drive_if #(
  parameter int P_PERIOD_W = 16,
  parameter int P_PWM_BITS = 8
);
  import led_pkg::*;

  logic                  i_cfg_valid;
  logic                  o_cfg_ready;
  logic [CH_W-1:0]       i_cfg_ch;
  mode_t                 i_cfg_mode;
  logic [P_PERIOD_W-1:0] i_cfg_period_ms;
  logic [P_PWM_BITS-1:0] i_cfg_duty;
  logic                  o_cfg_err;

  modport master (
    output i_cfg_valid, i_cfg_ch, i_cfg_mode,
    output i_cfg_period_ms, i_cfg_duty,
    input  o_cfg_ready, o_cfg_err
  );

  modport slave (
    input  i_cfg_valid, i_cfg_ch, i_cfg_mode,
    input  i_cfg_period_ms, i_cfg_duty,
    output o_cfg_ready, o_cfg_err
  );

endinterface

// File: rtl/led_pwm_drive_channel.sv
// One LED channel: config registers, ms step counter,
// blink phase, breathe level/direction and output flop.
module led_channel
  import led_pkg::*;
#(
  parameter int   P_PWM_BITS      = 8,
  parameter int   P_PERIOD_W      = 16,
  parameter int   P_DEF_PERIOD_MS = 1000,
  parameter logic P_LED_ON        = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  mode_t                 mode,
  input  logic [P_PERIOD_W-1:0] period,
  input  logic [P_PWM_BITS-1:0] duty,
  input  logic                  tick,
  input  logic [P_PWM_BITS-1:0] pwm_cnt,
  output logic                  led
);

  typedef struct packed {
    mode_t                 mode;
    logic [P_PERIOD_W-1:0] period;
    logic [P_PWM_BITS-1:0] duty;
  } ch_cfg_t;

  localparam logic [P_PWM_BITS-1:0] PWM_MAX = '1;

  ch_cfg_t               cfg_q;
  logic [P_PERIOD_W-1:0] ms_cnt;
  logic [P_PERIOD_W-1:0] last_ms;
  logic [P_PWM_BITS-1:0] level;
  logic [P_PWM_BITS-1:0] level_up;
  logic [P_PWM_BITS-1:0] level_dn;
  logic                  phase;
  logic                  dir_up;
  logic                  step;
  logic                  active;

  function automatic logic pwm_on(
    input logic [P_PWM_BITS-1:0] cnt,
    input logic [P_PWM_BITS-1:0] x
  );
    return (cnt < x) || (x == PWM_MAX);
  endfunction

  // period 0 behaves like period 1
  assign last_ms  = (cfg_q.period == '0) ? '0
                  : cfg_q.period - 1'b1;
  assign step     = tick & (ms_cnt == last_ms);
  assign level_up = level + 1'b1;
  assign level_dn = level - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= '{mode:   MODE_OFF,
                  period: P_PERIOD_W'(P_DEF_PERIOD_MS),
                  duty:   '1};
      ms_cnt <= '0;
      phase  <= 1'b1;
      level  <= '0;
      dir_up <= 1'b1;
    end else if (wr) begin
      cfg_q  <= '{mode: mode, period: period, duty: duty};
      ms_cnt <= '0;
      phase  <= 1'b1;
      level  <= '0;
      dir_up <= 1'b1;
    end else if (tick) begin
      ms_cnt <= step ? '0 : ms_cnt + 1'b1;
      if (step) begin
        phase <= ~phase;
        if (cfg_q.mode == MODE_BREATHE) begin
          if (cfg_q.duty == '0) begin
            level <= '0;
          end else if (dir_up) begin
            level <= level_up;
            if (level_up == cfg_q.duty) dir_up <= 1'b0;
          end else begin
            level <= level_dn;
            if (level_dn == '0) dir_up <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    active = 1'b0;
    unique case (cfg_q.mode)
      MODE_OFF:     active = 1'b0;
      MODE_ON:      active = pwm_on(pwm_cnt, cfg_q.duty);
      MODE_BLINK:   active = phase
                           & pwm_on(pwm_cnt, cfg_q.duty);
      MODE_BREATHE: active = pwm_on(pwm_cnt, level);
      default:      active = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= ~P_LED_ON;
    else        led <= active ? P_LED_ON : ~P_LED_ON;
  end

endmodule

// File: rtl/led_pwm_drive.sv
// Multi-channel LED driver top: ms prescaler, PWM counter,
// config decode and error pulse, one led_channel per LED.
module led_pwm_drive
  import led_pkg::*;
#(
  parameter int   P_LED_NUMBER    = 2,
  parameter int   P_CLK_KHZ       = 5000,
  parameter logic P_LED_ON        = 1'b1,
  parameter int   P_PWM_BITS      = 8,
  parameter int   P_PERIOD_W      = 16,
  parameter int   P_DEF_PERIOD_MS = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  led_pwm_drive_if.slave          cfg,
  output logic [P_LED_NUMBER-1:0] o_led
);

  localparam int PRE_W =
    (P_CLK_KHZ > 1) ? $clog2(P_CLK_KHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX =
    PRE_W'(P_CLK_KHZ - 1);
  localparam logic [CH_W:0] NCH = (CH_W+1)'(P_LED_NUMBER);

  logic [PRE_W-1:0]      pre_cnt;
  logic [P_PWM_BITS-1:0] pwm_cnt;
  logic                  tick;
  logic                  ready_q;
  logic                  err_q;
  logic                  accept;
  logic                  ch_ok;

  assign tick   = (pre_cnt == PRE_MAX);
  assign accept = cfg.i_cfg_valid & ready_q;
  assign ch_ok  = ({1'b0, cfg.i_cfg_ch} < NCH);

  assign cfg.o_cfg_ready = ready_q;
  assign cfg.o_cfg_err   = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      ready_q <= 1'b1;
      err_q   <= accept & ~ch_ok;
    end
  end

  for (genvar n = 0; n < P_LED_NUMBER; n++) begin : g_ch
    logic wr;
    assign wr = accept && (cfg.i_cfg_ch == CH_W'(n));

    led_channel #(
      .P_PWM_BITS      (P_PWM_BITS),
      .P_PERIOD_W      (P_PERIOD_W),
      .P_DEF_PERIOD_MS (P_DEF_PERIOD_MS),
      .P_LED_ON        (P_LED_ON)
    ) u_ch (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .wr      (wr),
      .mode    (cfg.i_cfg_mode),
      .period  (cfg.i_cfg_period_ms),
      .duty    (cfg.i_cfg_duty),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .led     (o_led[n])
    );
  end

endmodule

// File: tb/tb_led_pwm_drive.sv
// Scoreboard bench for led_pwm_drive: a time-based model
// predicts every output cycle; a monitor pops and compares.
module tb_led_pwm_drive;
  import led_pkg::*;

  localparam int NCH = 2;
  localparam int KHZ = 10;
  localparam int PB  = 8;
  localparam int PW  = 16;

  typedef struct packed {
    logic [NCH-1:0] led;
    logic           rdy;
    logic           err;
  } obs_t;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] led;

  led_pwm_drive_if #(.P_PERIOD_W(PW), .P_PWM_BITS(PB)) cfg ();

  led_pwm_drive #(
    .P_LED_NUMBER    (NCH),
    .P_CLK_KHZ       (KHZ),
    .P_LED_ON        (1'b1),
    .P_PWM_BITS      (PB),
    .P_PERIOD_W      (PW),
    .P_DEF_PERIOD_MS (1000)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .cfg     (cfg),
    .o_led   (led)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   err_seen = 0;
  int   edge_n = 0;
  cfg_t mcfg [NCH];
  int   mw   [NCH];
  obs_t expq [$];

  function automatic logic pwm_on(int pwm, int x);
    return (pwm < x) || (x == 255);
  endfunction

  // Output after state s: counts ms ticks since the write,
  // turns them into step events and derives the waveform.
  function automatic logic exp_led(int n, int s);
    int p, d, k, st, pwm, lvl, m;
    p   = (mcfg[n].period == 0) ? 1 : int'(mcfg[n].period);
    d   = int'(mcfg[n].duty);
    k   = s / KHZ - mw[n] / KHZ;
    st  = k / p;
    pwm = s % 256;
    case (mcfg[n].mode)
      MODE_ON:    return pwm_on(pwm, d);
      MODE_BLINK: return (st % 2 == 0) && pwm_on(pwm, d);
      MODE_BREATHE: begin
        if (d == 0) lvl = 0;
        else begin
          m   = st % (2 * d);
          lvl = (m <= d) ? m : 2 * d - m;
        end
        return pwm_on(pwm, lvl);
      end
      default:    return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    obs_t o;
    int   c;
    o = '0;
    if (!rst_n) begin
      edge_n = 0;
      for (int n = 0; n < NCH; n++) begin
        mcfg[n] = '{mode: MODE_OFF, period: 16'd1000,
                    duty: 8'hFF};
        mw[n]   = 0;
      end
    end else begin
      edge_n++;
      for (int n = 0; n < NCH; n++)
        o.led[n] = exp_led(n, edge_n - 1);
      o.rdy = 1'b1;
      if (cfg.i_cfg_valid && edge_n >= 2) begin
        c = int'(cfg.i_cfg_ch);
        if (c < NCH) begin
          mcfg[c] = '{mode: cfg.i_cfg_mode,
                      period: cfg.i_cfg_period_ms,
                      duty: cfg.i_cfg_duty};
          mw[c]   = edge_n;
        end else begin
          o.err = 1'b1;
        end
      end
    end
    expq.push_back(o);
  end

  always @(negedge clk) begin : monitor
    obs_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      total++;
      if (led !== e.led) begin
        bad++;
        $display("FAIL led t=%0t got=%b exp=%b",
                 $time, led, e.led);
      end
      total++;
      if ({cfg.o_cfg_ready, cfg.o_cfg_err} !== {e.rdy, e.err}) begin
        bad++;
        $display("FAIL ctrl t=%0t got rdy/err=%b%b exp=%b%b",
                 $time, cfg.o_cfg_ready, cfg.o_cfg_err,
                 e.rdy, e.err);
      end
      if (cfg.o_cfg_err === 1'b1) err_seen++;
    end
  end

  task automatic check(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wr(int ch, mode_t m, int per, int duty);
    @(negedge clk);
    cfg.i_cfg_valid     = 1'b1;
    cfg.i_cfg_ch        = 4'(ch);
    cfg.i_cfg_mode      = m;
    cfg.i_cfg_period_ms = 16'(per);
    cfg.i_cfg_duty      = 8'(duty);
    @(negedge clk);
    cfg.i_cfg_valid     = 1'b0;
  endtask

  task automatic count_high(int n, int cycles, output int hi);
    hi = 0;
    repeat (cycles) begin
      @(negedge clk);
      hi += int'(led[n]);
    end
  endtask

  task automatic do_reset(int cycles);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", int'(led), 0);
    check("async_rdy", int'(cfg.o_cfg_ready), 0);
    repeat (cycles) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int hi, ch, per, duty, e0;
    mode_t m;
    cfg.i_cfg_valid     = 1'b0;
    cfg.i_cfg_ch        = '0;
    cfg.i_cfg_mode      = MODE_OFF;
    cfg.i_cfg_period_ms = '0;
    cfg.i_cfg_duty      = '0;
    #1;
    check("rst_led", int'(led), 0);
    check("rst_rdy", int'(cfg.o_cfg_ready), 0);
    check("rst_err", int'(cfg.o_cfg_err), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    count_high(0, 2500, hi);
    check("idle0_high", hi, 0);
    count_high(1, 2500, hi);
    check("idle1_high", hi, 0);

    wr(0, MODE_ON, 1, 8'hFF);
    count_high(0, 300, hi);
    check("on_ff_high", hi, 300);
    wr(0, MODE_ON, 1, 8'h40);
    repeat (4) @(negedge clk);
    count_high(0, 256, hi);
    check("on_40_high", hi, 64);

    wr(1, MODE_BLINK, 3, 8'hFF);
    repeat (10) @(negedge clk);
    count_high(1, 60, hi);
    check("blink_60", hi, 30);
    count_high(0, 256, hi);
    check("ch0_kept", hi, 64);

    wr(0, MODE_BREATHE, 1, 4);
    repeat (300) @(negedge clk);

    e0 = err_seen;
    wr(5, MODE_ON, 1, 0);
    repeat (20) @(negedge clk);
    check("err_pulses", err_seen - e0, 1);
    count_high(1, 60, hi);
    check("blink_after_err", hi, 30);

    wr(0, MODE_ON, 0, 8'hFF);
    repeat (50) @(negedge clk);
    do_reset(3);
    repeat (200) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      ch  = $urandom_range(0, 3);
      m   = mode_t'($urandom_range(0, 3));
      per = $urandom_range(0, 4);
      duty = (m == MODE_BREATHE) ? $urandom_range(0, 6)
                                 : $urandom_range(0, 255);
      wr(ch, m, per, duty);
      repeat ($urandom_range(0, 250)) @(negedge clk);
      if (i == 25) do_reset($urandom_range(1, 4));
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
